// File: rtl/multi_core_controller_if.sv
// multi_core_controller_if: register port between the host-side bridge and multi_core_controller
//   master: host side, drives strobes/address/write data, receives read data and its valid pulse
//   slave : controller side
interface multi_core_controller_if #(
    parameter int ADDR_W = 6
);
    logic              REG_WE;
    logic              REG_RE;
    logic [ADDR_W-1:0] REG_ADDR;
    logic [31:0]       REG_WDATA;
    logic [31:0]       REG_RDATA;
    logic              REG_RVALID;
    modport master (output REG_WE, REG_RE, REG_ADDR, REG_WDATA, input REG_RDATA, REG_RVALID);
    modport slave (input REG_WE, REG_RE, REG_ADDR, REG_WDATA, output REG_RDATA, REG_RVALID);
endinterface

// File: rtl/multi_core_controller.sv
// multi_core_controller: supervises NUM_CORES cores (reset, status, halt, run-cycle count) from one register port
//   CCLK, CRST : core clock, asynchronous active-high reset
//   CSTAT      : per-core 8-bit status, core i at [8i+7:8i]
//   CORE_RST   : per-core reset, active-high
//   IRQ        : high while any core is halted with its irq_en set
//   bus        : register port, word address {core, offset}, read data one cycle after REG_RE
module multi_core_controller #(
    parameter int         NUM_CORES = 4,
    parameter int         CNT_WIDTH = 32,
    parameter int         RST_HOLD  = 16,
    parameter logic [7:0] HALT_CODE = 8'hFF,
    parameter int         ADDR_W    = 6
) (
    input  logic                     CCLK,
    input  logic                     CRST,
    input  logic [8*NUM_CORES-1:0]   CSTAT,
    output logic [NUM_CORES-1:0]     CORE_RST,
    output logic                     IRQ,
    multi_core_controller_if.slave   bus
);
    localparam int PW = $clog2(RST_HOLD + 1);
    localparam int IW = ADDR_W - 2;
    localparam int CW = NUM_CORES > 1 ? $clog2(NUM_CORES) : 1;
    localparam logic [IW:0] NC = NUM_CORES[IW:0];

    logic [IW-1:0]          idx;
    logic [CW-1:0]          ci;
    logic [1:0]             off;
    logic                   hit;
    logic [NUM_CORES-1:0]   hold, hold_n, irq_en, halted, wr_ctrl, w1c;
    logic [PW-1:0]          pcnt [NUM_CORES];
    logic [PW-1:0]          pcnt_n [NUM_CORES];
    logic [7:0]             stat_q [NUM_CORES];
    logic [CNT_WIDTH-1:0]   cnt [NUM_CORES];
    logic [31:0]            rd;
    logic                   unused_wdata;

    assign idx = bus.REG_ADDR[ADDR_W-1:2];
    assign off = bus.REG_ADDR[1:0];
    assign ci  = CW'(idx);
    assign hit = {1'b0, idx} < NC;
    assign unused_wdata = ^{bus.REG_WDATA[31:9], bus.REG_WDATA[7:3]};

    always_comb begin
        for (int c = 0; c < NUM_CORES; c++) begin
            wr_ctrl[c] = bus.REG_WE && hit && ci == CW'(c) && off == 2'd0;
            w1c[c]     = bus.REG_WE && hit && ci == CW'(c) && off == 2'd1 && bus.REG_WDATA[8];
            hold_n[c]  = wr_ctrl[c] ? bus.REG_WDATA[0] : hold[c];
            // a pulse write restarts the count rather than adding to it
            pcnt_n[c]  = wr_ctrl[c] && bus.REG_WDATA[1] ? PW'(RST_HOLD)
                       : pcnt[c] != '0 ? pcnt[c] - 1'b1 : pcnt[c];
        end
    end

    always_comb begin
        rd = '0;
        if (hit)
            rd = off == 2'd0 ? {29'd0, irq_en[ci], 1'b0, hold[ci]}
               : off == 2'd1 ? {22'd0, CORE_RST[ci], halted[ci], stat_q[ci]}
               : off == 2'd2 ? 32'(cnt[ci])
               : {16'd0, HALT_CODE, 8'(NUM_CORES)};
    end

    always_ff @(posedge CCLK or posedge CRST) begin
        if (CRST) begin
            for (int c = 0; c < NUM_CORES; c++) begin
                pcnt[c]   <= '0;
                stat_q[c] <= '0;
                cnt[c]    <= '0;
            end
            hold           <= '1;
            irq_en         <= '0;
            halted         <= '0;
            CORE_RST       <= '1;
            IRQ            <= 1'b0;
            bus.REG_RDATA  <= '0;
            bus.REG_RVALID <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_CORES; c++) begin
                pcnt[c]   <= pcnt_n[c];
                stat_q[c] <= CSTAT[8*c +: 8];
                // a set condition outranks a same-cycle W1C
                halted[c] <= !CORE_RST[c] && (stat_q[c] == HALT_CODE || (halted[c] && !w1c[c]));
                cnt[c]    <= CORE_RST[c] ? '0 : halted[c] || cnt[c] == '1 ? cnt[c] : cnt[c] + 1'b1;
            end
            hold           <= hold_n;
            irq_en         <= (irq_en & ~wr_ctrl) | (wr_ctrl & {NUM_CORES{bus.REG_WDATA[2]}});
            for (int c = 0; c < NUM_CORES; c++)
                CORE_RST[c] <= hold_n[c] | (pcnt_n[c] != '0);
            IRQ            <= |(halted & irq_en);
            bus.REG_RVALID <= bus.REG_RE;
            if (bus.REG_RE)
                bus.REG_RDATA <= rd;
        end
    end
endmodule

// File: doc/multi_core_controller.md
Name: multi_core_controller

Overview:
Parametrised successor to the single-core controller: supervises NUM_CORES cores from one register port.
- Per core: reset hold and timed reset pulse, synchronised status capture, halt detection with sticky flag, saturating run-cycle counter.
- Combined interrupt output.
- Sits between the host-side register bridge and the core array; everything runs on the core clock.

Parameters:
NUM_CORES, 4, number of supervised cores (1..16)
CNT_WIDTH, 32, width of each run-cycle counter (8..32)
RST_HOLD, 16, CORE_RST pulse length in cycles for a pulse request (>=1)
HALT_CODE, 8'hFF, CSTAT value that marks a core as halted
ADDR_W, 6, register word-address width (>= clog2(NUM_CORES)+2)

Ports:
CCLK  in  1  core clock; all logic on rising edge
CRST  in  1  reset; asynchronous, active-high
CSTAT  in  8*NUM_CORES  per-core status; core i = bits [8i+7:8i]
CORE_RST  out  NUM_CORES  per-core reset, active-high
REG_WE  in  1  register write strobe, one cycle per write
REG_RE  in  1  register read strobe, one cycle per read
REG_ADDR  in  ADDR_W  word address = {core index, 2-bit offset}
REG_WDATA  in  32  write data
REG_RDATA  out  32  read data, valid when REG_RVALID
REG_RVALID  out  1  read-data valid pulse
IRQ  out  1  high while any core has halted=1 and irq_en=1

Behaviour:
Reset (CRST high, asynchronous):
- hold=1, pulse_cnt=0, irq_en=0, halted=0, counters=0, status regs=0.
- CORE_RST all 1, REG_RDATA=0, REG_RVALID=0, IRQ=0.

Register map per core i (offset = REG_ADDR[1:0]):
- 0 CTRL
  - bit0 hold: R/W.
  - bit1 pulse: write-1 starts a reset pulse; reads 0.
  - bit2 irq_en: R/W.
- 1 STATUS
  - [7:0] registered CSTAT: RO.
  - bit8 halted: W1C.
  - bit9 CORE_RST[i]: RO.
- 2 CYCLES: counter zero-extended to 32 bits; RO.
- 3 ID: [7:0] = NUM_CORES, [15:8] = HALT_CODE; RO.

Addressing:
- Core index >= NUM_CORES: reads return 0, writes are ignored.
- Writes to RO bits are ignored.

Read timing:
- REG_RE at cycle t -> REG_RDATA and REG_RVALID=1 at t+1. REG_RVALID is a single-cycle pulse.
- REG_RDATA holds its last value when not valid.
- Simultaneous REG_WE and REG_RE: the read returns the pre-write value.

Reset control:
- CORE_RST[i] = hold | (pulse_cnt != 0), registered; asserts the cycle after the write.
- A pulse write loads pulse_cnt = RST_HOLD. It decrements each cycle to 0, giving exactly RST_HOLD cycles of CORE_RST.
- A pulse write while a pulse is active reloads RST_HOLD (restart, no accumulation).
- Writing hold=1 together with pulse=1 is legal; CORE_RST stays 1 until both have cleared.

Status capture:
- CSTAT slice registered every cycle regardless of reset state.
- STATUS[7:0] shows the registered value, one cycle latency.

Halt detection:
- halted sets on the cycle the registered status == HALT_CODE and CORE_RST[i]=0.
- Sticky.
- Cleared by a W1C write, or forced 0 whenever CORE_RST[i]=1.
- A set condition and a W1C in the same cycle: set wins.

Cycle counter:
- Held at 0 while CORE_RST[i]=1.
- Otherwise +1 per cycle while halted=0.
- Freezes while halted=1.
- Saturates at 2^CNT_WIDTH-1; no wrap.

IRQ: registered OR over cores of (halted & irq_en); one cycle after the contributing flag changes.

Mid-operation CRST: immediate return to the reset state, including an in-flight pulse and a pending read (no REG_RVALID emitted).

Test Plan:
- Release CRST; read CTRL core0 -> 0x1, CORE_RST=4'b1111, CYCLES=0. Write CTRL core0 = 0 -> CORE_RST[0]=0 next cycle; after 100 cycles CYCLES reads 100 ±1 (fixed by read latency).
- Core1 running; write CTRL core1 = 0x2 with RST_HOLD=16 -> CORE_RST[1] high exactly 16 cycles, counter 0 throughout, then restarts from 0. A second pulse write at cycle 10 -> 26 total high cycles.
- Core2 running, irq_en=1; drive CSTAT[23:16]=0xFF -> halted=1 and counter frozen two cycles later, IRQ=1 one cycle after that. W1C STATUS bit8 while CSTAT still 0xFF -> halted remains 1. Set CSTAT=0x00, then W1C -> halted=0, IRQ=0.
- CNT_WIDTH=8: run core 300 cycles -> CYCLES=255 (saturated, no wrap).
- Read core index 5 with NUM_CORES=4 -> REG_RDATA=0, REG_RVALID=1; write there -> no state change. Simultaneous write and read of CTRL core0 -> read returns the old value.
- Assert CRST mid-pulse and on a read cycle -> CORE_RST all 1 asynchronously, no REG_RVALID, IRQ=0, all counters 0.
